// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the memory arbiter.
// slave is the arbiter's view of the bus; master is the caches' and memory's view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  inst_read;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [LINE_WIDTH-1:0] inst_rdata;
  logic                  inst_resp;
  logic                  data_read;
  logic                  data_write;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [LINE_WIDTH-1:0] data_wdata;
  logic [LINE_WIDTH-1:0] data_rdata;
  logic                  data_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  modport slave (
    input  inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, pmem_rdata, pmem_resp,
    output inst_rdata, inst_resp, data_rdata, data_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
  modport master (
    output inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, pmem_rdata, pmem_resp,
    input  inst_rdata, inst_resp, data_rdata, data_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache and D-cache, one line transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is data-wins fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_INST, SERVE_DATA} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  read_q;
  logic                  write_q;
  logic                  inst_req;
  logic                  data_req;
  logic                  favour_data;
  logic                  grant_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  rr_data_q;
  assign favour_data = rr_data_q;
`else
  assign favour_data = 1'b1;
`endif
  assign inst_req   = bus.inst_read;
  assign data_req   = bus.data_read | bus.data_write;
  assign grant_data = data_req & (~inst_req | favour_data);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_data_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (inst_req | data_req) begin
          state_q <= grant_data ? SERVE_DATA : SERVE_INST;
          addr_q  <= grant_data ? bus.data_addr : bus.inst_addr;
          wdata_q <= grant_data ? bus.data_wdata : '0;
          write_q <= grant_data & bus.data_write;
          read_q  <= ~(grant_data & bus.data_write);
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_data_q <= ~grant_data;
`endif
        end
        SERVE_INST, SERVE_DATA: if (bus.pmem_resp) begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end
  assign bus.pmem_read  = read_q;
  assign bus.pmem_write = write_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.inst_resp  = (state_q == SERVE_INST) & bus.pmem_resp;
  assign bus.data_resp  = (state_q == SERVE_DATA) & bus.pmem_resp;
  assign bus.inst_rdata = bus.pmem_rdata;
  assign bus.data_rdata = bus.pmem_rdata;
endmodule
